// File: rtl/matmul_scratchpad_pkg.sv
// Shared definitions for the matmul result scratchpad: operand codes, read FSM
// states and the geometry helpers used to size storage and address fields.
package matmul_scratchpad_pkg;

    localparam logic [4:0] OP_A = 5'b00100;
    localparam logic [4:0] OP_B = 5'b01000;
    localparam logic [4:0] OP_C = 5'b10000;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_STREAM,
        RD_HOLD
    } rd_state_e;

    function automatic int unsigned max_dim(int unsigned bus_w, int unsigned data_w);
        return bus_w / data_w;
    endfunction

    function automatic int unsigned nelem(int unsigned bus_w, int unsigned data_w);
        return max_dim(bus_w, data_w) * max_dim(bus_w, data_w);
    endfunction

    function automatic int unsigned idx_width(int unsigned bus_w, int unsigned data_w);
        int unsigned w;
        w = 2 * $clog2(max_dim(bus_w, data_w));
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned bank_width(int unsigned ntargets);
        return (ntargets > 1) ? $clog2(ntargets) : 1;
    endfunction

endpackage

// File: rtl/matmul_scratchpad_if.sv
// Write/read bundle between the matmul calc stage (master) and the result
// scratchpad (slave).
interface matmul_scratchpad_if
    import matmul_scratchpad_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned SP_NTARGETS = 4
);
    localparam int unsigned BW = bank_width(SP_NTARGETS);

    logic                   wr_en_i;
    logic [ADDR_WIDTH-1:0]  wr_addr_i;
    logic [BUS_WIDTH-1:0]   wr_data_i;
    logic                   wr_done_i;
    logic [BW-1:0]          wr_bank_i;
    logic [BUS_WIDTH-1:0]   flags_i;
    logic                   rd_start_i;
    logic [BW-1:0]          rd_bank_i;
    logic [BUS_WIDTH-1:0]   rd_data_o;
    logic                   rd_valid_o;
    logic [BUS_WIDTH-1:0]   rd_flags_o;
    logic [SP_NTARGETS-1:0] bank_valid_o;
    logic                   done_o;
    logic                   err_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, wr_done_i, wr_bank_i, flags_i,
               rd_start_i, rd_bank_i,
        input  rd_data_o, rd_valid_o, rd_flags_o, bank_valid_o, done_o, err_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, wr_done_i, wr_bank_i, flags_i,
               rd_start_i, rd_bank_i,
        output rd_data_o, rd_valid_o, rd_flags_o, bank_valid_o, done_o, err_o
    );

endinterface

// File: rtl/matmul_sp_reader.sv
// Read-stream FSM: presents NELEM elements of the selected bank, one per cycle,
// on a registered data output, then holds zero until the request drops.
module matmul_sp_reader
    import matmul_scratchpad_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 16,
    parameter int unsigned NELEM     = 4,
    parameter int unsigned IW        = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rd_start_i,
    input  logic [BUS_WIDTH-1:0] rd_elem_i,
    output logic [IW-1:0]        rd_idx_o,
    output logic [BUS_WIDTH-1:0] rd_data_o,
    output logic                 rd_valid_o,
    output logic                 last_o
);
    localparam logic [IW-1:0] LAST_IDX = IW'(NELEM - 1);

    rd_state_e            state_q, state_d;
    logic [IW-1:0]        cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] data_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RD_IDLE;
            cnt_q     <= '0;
            rd_data_o <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_data_o <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE:   if (rd_start_i) state_d = (NELEM == 1) ? RD_HOLD : RD_STREAM;
            RD_STREAM: if (!rd_start_i) state_d = RD_IDLE;
                       else if (cnt_q == LAST_IDX) state_d = RD_HOLD;
            RD_HOLD:   if (!rd_start_i) state_d = RD_IDLE;
            default:   state_d = RD_IDLE;
        endcase
    end

    // cnt_q is the index currently on rd_data_o; rd_idx_o selects the next one.
    always_comb begin
        rd_idx_o   = '0;
        cnt_d      = '0;
        data_d     = rd_elem_i;
        rd_valid_o = 1'b0;
        last_o     = 1'b0;
        case (state_q)
            RD_IDLE: begin
                rd_valid_o = rd_start_i & rst_ni;
                if (rd_start_i) begin
                    if (NELEM == 1) begin
                        last_o = 1'b1;
                        data_d = '0;
                    end else begin
                        rd_idx_o = IW'(1);
                        cnt_d    = IW'(1);
                    end
                end
            end
            RD_STREAM: begin
                rd_valid_o = 1'b1;
                if (rd_start_i) begin
                    if (cnt_q == LAST_IDX) begin
                        last_o = 1'b1;
                        data_d = '0;
                    end else begin
                        rd_idx_o = cnt_q + IW'(1);
                        cnt_d    = cnt_q + IW'(1);
                    end
                end
            end
            RD_HOLD: if (rd_start_i) data_d = '0;
            default: data_d = '0;
        endcase
    end

endmodule

// File: rtl/matmul_scratchpad.sv
// Banked result scratchpad for the matmul calc stage: C-element write decode,
// per-bank storage and commit bits, consume-once read streaming.
// Optional per-bank flag storage is enabled by defining MATMUL_SP_FLAGS_EN.
module matmul_scratchpad
    import matmul_scratchpad_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BUS_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned SP_NTARGETS = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    matmul_scratchpad_if.slave sp
);
    localparam int unsigned NELEM = nelem(BUS_WIDTH, DATA_WIDTH);
    localparam int unsigned IW    = idx_width(BUS_WIDTH, DATA_WIDTH);
    localparam int unsigned BW    = bank_width(SP_NTARGETS);

    logic [BUS_WIDTH-1:0]   mem [SP_NTARGETS][NELEM];
    logic [SP_NTARGETS-1:0] bank_valid_q;
    logic                   done_q, err_q;
    logic [IW-1:0]          wr_idx, rd_idx;
    logic                   idx_ok, wr_ok;
    logic [BUS_WIDTH-1:0]   rd_elem, rd_data;
    logic                   rd_valid, rd_last;

    assign wr_idx = sp.wr_addr_i[5 +: IW];

    if ((1 << IW) > NELEM) begin : g_idx_chk
        assign idx_ok = (int'(wr_idx) < int'(NELEM));
    end else begin : g_idx_full
        assign idx_ok = 1'b1;
    end

    assign wr_ok = sp.wr_en_i && (sp.wr_addr_i[4:0] == OP_C) && idx_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned b = 0; b < SP_NTARGETS; b++)
                for (int unsigned e = 0; e < NELEM; e++)
                    mem[b][e] <= '0;
            bank_valid_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (wr_ok)
                mem[sp.wr_bank_i][wr_idx] <= sp.wr_data_i;
            if (sp.wr_en_i && !wr_ok)
                err_q <= 1'b1;
            done_q <= sp.wr_done_i;
            // A commit to a bank outranks the consume-once clear of that bank.
            for (int unsigned b = 0; b < SP_NTARGETS; b++) begin
                if (sp.wr_done_i && (sp.wr_bank_i == BW'(b)))
                    bank_valid_q[b] <= 1'b1;
                else if (rd_last && (sp.rd_bank_i == BW'(b)))
                    bank_valid_q[b] <= 1'b0;
            end
        end
    end

    assign rd_elem = bank_valid_q[sp.rd_bank_i] ? mem[sp.rd_bank_i][rd_idx] : '0;

    matmul_sp_reader #(
        .BUS_WIDTH (BUS_WIDTH),
        .NELEM     (NELEM),
        .IW        (IW)
    ) u_reader (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_start_i (sp.rd_start_i),
        .rd_elem_i  (rd_elem),
        .rd_idx_o   (rd_idx),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .last_o     (rd_last)
    );

`ifdef MATMUL_SP_FLAGS_EN
    logic [BUS_WIDTH-1:0] flags_q [SP_NTARGETS];
    logic [BUS_WIDTH-1:0] rd_flags_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned b = 0; b < SP_NTARGETS; b++)
                flags_q[b] <= '0;
            rd_flags_q <= '0;
        end else begin
            if (sp.wr_done_i)
                flags_q[sp.wr_bank_i] <= sp.flags_i;
            rd_flags_q <= flags_q[sp.rd_bank_i];
        end
    end

    assign sp.rd_flags_o = rd_flags_q;
`else
    logic unused_flags;
    assign unused_flags  = ^sp.flags_i;
    assign sp.rd_flags_o = '0;
`endif

    if (ADDR_WIDTH > 5 + IW) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^sp.wr_addr_i[ADDR_WIDTH-1:5+IW];
    end

    assign sp.rd_data_o    = rd_data;
    assign sp.rd_valid_o   = rd_valid;
    assign sp.bank_valid_o = bank_valid_q;
    assign sp.done_o       = done_q;
    assign sp.err_o        = err_q;

endmodule

// File: doc/matmul_scratchpad.md
MATMUL_SCRATCHPAD -- requirements
Module: matmul_scratchpad

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the matrix element width in bits.
REQ-002 Parameter BUS_WIDTH, default 16, SHALL set the stored C element width; MAX_DIM = BUS_WIDTH/DATA_WIDTH, NELEM = MAX_DIM*MAX_DIM.
REQ-003 Parameter ADDR_WIDTH, default 32, SHALL set the write address width.
REQ-004 Parameter SP_NTARGETS, default 4, SHALL set the number of result banks; BW = clog2(SP_NTARGETS).
REQ-005 clk_i  in  1  clock; all state updates on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 wr_en_i  in  1  write strobe from the matmul calc stage.
REQ-008 wr_addr_i  in  ADDR_WIDTH  write address: [4:0] operand code, [5 +: 2*clog2(MAX_DIM)] element index.
REQ-009 wr_data_i  in  BUS_WIDTH  C element to store.
REQ-010 wr_done_i  in  1  end-of-result pulse from the calc stage.
REQ-011 wr_bank_i  in  BW  destination bank for writes and wr_done_i.
REQ-012 flags_i  in  BUS_WIDTH  overflow flags, sampled on wr_done_i.
REQ-013 rd_start_i  in  1  read-stream request, level, held high by the consumer for the whole operation.
REQ-014 rd_bank_i  in  BW  source bank for the read stream.
REQ-015 rd_data_o  out  BUS_WIDTH  registered C bias element to the calc stage.
REQ-016 rd_valid_o  out  1  high while rd_data_o carries a streamed element.
REQ-017 rd_flags_o  out  BUS_WIDTH  stored flags of rd_bank_i (see Configuration).
REQ-018 bank_valid_o  out  SP_NTARGETS  per-bank "result committed" bits.
REQ-019 done_o  out  1  one-cycle pulse, one cycle after wr_done_i.
REQ-020 err_o  out  1  sticky illegal-write indicator.

Function
REQ-021 A write SHALL occur when wr_en_i=1 and wr_addr_i[4:0]=5'b10000; it stores wr_data_i into mem[wr_bank_i][index], visible to reads from the next cycle.
REQ-022 wr_en_i=1 with any other operand code, or with an index >= NELEM, SHALL store nothing and set err_o until reset.
REQ-023 wr_done_i=1 SHALL set bank_valid_o[wr_bank_i] and pulse done_o on the following cycle; a write and wr_done_i in the same cycle SHALL both take effect.
REQ-024 Read FSM states: IDLE, STREAM, HOLD.
REQ-025 IDLE: rd_data_o SHALL be reloaded every cycle with element 0 of rd_bank_i; rd_valid_o=0 while rd_start_i=0; rd_start_i=1 -> STREAM.
REQ-026 STREAM: the element index SHALL advance by one per cycle, so the consumer samples element k on the k-th rising edge after rd_start_i rises (k = 0..NELEM-1); rd_valid_o=1 while element 0..NELEM-1 is presented.
REQ-027 After element NELEM-1 is presented -> HOLD: rd_data_o=0, rd_valid_o=0.
REQ-028 rd_start_i falling in STREAM or HOLD SHALL return to IDLE on the next edge; a new stream SHALL always restart at element 0.
REQ-029 A bank with bank_valid_o=0 SHALL stream zeros.
REQ-030 A read and a write to the same bank/element in the same cycle SHALL return the old data.
REQ-031 bank_valid_o[b] SHALL clear on the cycle after a stream of bank b completes (consume-once), unless wr_done_i targets b in that cycle.

Reset
REQ-032 rst_ni low SHALL immediately clear all memory, bank_valid_o, err_o, done_o, rd_valid_o, rd_data_o and rd_flags_o, and force the FSM to IDLE, including mid-stream.

Configuration
REQ-033 With MATMUL_SP_FLAGS_EN defined, flags_i SHALL be stored per bank on wr_done_i and rd_flags_o SHALL show the flags of rd_bank_i; without it, no flag storage SHALL exist and rd_flags_o SHALL be 0.

Structure
REQ-034 A shared package SHALL hold the operand codes (A=5'b00100, B=5'b01000, C=5'b10000) and the MAX_DIM/NELEM derivation functions.
REQ-035 The read FSM SHALL be a sub-module matmul_sp_reader; storage and write decode SHALL stay in the top level.

Verification (defaults, NELEM=4)
REQ-036 Writes C codes with indices 0..3 and data 0x0011,0x0022,0x0033,0x0044 to bank 1, then wr_done_i -> done_o pulses one cycle later and bank_valid_o=4'b0010.
REQ-037 rd_bank_i=1, rd_start_i high for 6 cycles -> edges 0..3 sample 0x0011..0x0044 with rd_valid_o=1, then rd_data_o=0, and bank_valid_o[1]=0 after the stream.
REQ-038 Write with wr_addr_i[4:0]=5'b00100 -> memory unchanged and err_o=1 until reset.
REQ-039 rst_ni pulsed low during element 2 of a stream -> all outputs 0 at once, FSM IDLE, and a new stream returns 0,0,0,0.
REQ-040 Same-cycle write of 0x7FFF to bank 2 element 0 while IDLE on bank 2 -> rd_data_o shows the old value, then 0x7FFF one cycle later.
REQ-041 flags_i=0x0005 with wr_done_i on bank 3 -> rd_flags_o=0x0005 for rd_bank_i=3 when MATMUL_SP_FLAGS_EN is defined, 0x0000 when it is not.
